uart_rx: RTL and testbench

- UART receive front end; the stage directly upstream of the receive FIFO.
- Synchronises the asynchronous serial line and oversamples it at 16x using an internal baud-tick generator.
- Assembles each frame LSB-first, with optional parity, and checks framing, parity and overrun.
- Emits one single-cycle write strobe plus a data byte per good frame, wired straight to the FIFO `wr`/`w_data` inputs.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_t    : receiver FSM encoding (3-bit)
//   OVERSAMPLE : oversample ticks per data/start/parity bit
//   MID_TICK   : tick index at the middle of the start bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_if.sv
// FIFO-side bundle of the UART receiver.
//   fifo_full   : FIFO full flag (into the receiver)
//   wr          : one-cycle write strobe
//   w_data      : received byte, valid while wr=1, held until next frame
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch
//   overrun_err : one-cycle pulse, good byte dropped because FIFO was full
// master = receiver side, slave = FIFO side.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            fifo_full;
    logic            wr;
    logic [DBIT-1:0] w_data;
    logic            frame_err;
    logic            parity_err;
    logic            overrun_err;

    modport master (
        input  fifo_full,
        output wr, w_data, frame_err, parity_err, overrun_err
    );

    modport slave (
        output fifo_full,
        input  wr, w_data, frame_err, parity_err, overrun_err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Mod-DVSR counter producing the 16x oversample tick.
//   clk, reset : system clock, async active-high reset
//   clr        : synchronous clear; counter held at 0 while asserted
//   tick       : high for the one cycle where count == DVSR-1
module uart_baud_gen #(
    parameter int DVSR   = 163,
    parameter int DVSR_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = !clr && (cnt == CNT_LAST);
endmodule

// File: rtl/uart_rx.sv
// UART receive front end feeding the receive FIFO.
// Synchronises rx, oversamples it 16x, assembles LSB-first frames with
// optional parity and reports exactly one outcome per completed frame.
//   clk, reset : system clock, async active-high reset
//   rx         : asynchronous serial line, idle high
//   fifo_if    : FIFO-side bundle (fifo_full in; wr, w_data, error pulses out)
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR       = 163,
    parameter int DVSR_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     rx,
    uart_rx_if.master fifo_if
);
    import uart_pkg::*;

    // s must count to 15 in data bits and to SB_TICK-1 in the stop bit.
    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = ($clog2(DBIT) > 0) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID       = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);
    localparam logic           ODD         = (PARITY_ODD != 0);

    logic            sync1, rx_s;
    state_t          state, state_n;
    logic [S_W-1:0]  s, s_n;
    logic [N_W-1:0]  n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            acc, acc_n;
    logic            perr, perr_n;
    logic            wr_n, fe_n, pe_n, oe_n, load_n;
    logic            tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    uart_baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            s                   <= '0;
            n                   <= '0;
            b                   <= '0;
            acc                 <= 1'b0;
            perr                <= 1'b0;
            fifo_if.wr          <= 1'b0;
            fifo_if.frame_err   <= 1'b0;
            fifo_if.parity_err  <= 1'b0;
            fifo_if.overrun_err <= 1'b0;
            fifo_if.w_data      <= '0;
        end else begin
            state               <= state_n;
            s                   <= s_n;
            n                   <= n_n;
            b                   <= b_n;
            acc                 <= acc_n;
            perr                <= perr_n;
            fifo_if.wr          <= wr_n;
            fifo_if.frame_err   <= fe_n;
            fifo_if.parity_err  <= pe_n;
            fifo_if.overrun_err <= oe_n;
            if (load_n)
                fifo_if.w_data <= b;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        acc_n   = acc;
        perr_n  = perr;
        wr_n    = 1'b0;
        fe_n    = 1'b0;
        pe_n    = 1'b0;
        oe_n    = 1'b0;
        load_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                            acc_n   = 1'b0;
                            perr_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (s == S_BIT_LAST) begin
                        // New bit enters at the MSB so LSB-first data ends up aligned.
                        b_n   = {rx_s, b[DBIT-1:1]};
                        acc_n = acc ^ rx_s;
                        s_n   = '0;
                        if (n == N_LAST)
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            n_n = n + 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    if (s == S_BIT_LAST) begin
                        perr_n  = ((acc ^ rx_s) != ODD);
                        state_n = STOP;
                        s_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (s == S_STOP_LAST) begin
                        state_n = IDLE;
                        load_n  = 1'b1;
                        if (!rx_s)
                            fe_n = 1'b1;
                        else if (perr)
                            pe_n = 1'b1;
                        else if (fifo_if.fifo_full)
                            oe_n = 1'b1;
                        else
                            wr_n = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DVSR=4 (64 clk per bit).
// dut_a: 8N1, dut_b: 8E1. Outcome pulses are counted at negedge so a
// pulse wider than one cycle shows up as an extra count.
module tb_uart_rx;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic reset;
    logic rx_a, rx_b;

    always #5 clk = ~clk;

    uart_rx_if #(.DBIT(8)) if_a ();
    uart_rx_if #(.DBIT(8)) if_b ();

    uart_rx #(
        .DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(8),
        .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx_a),
        .fifo_if (if_a)
    );

    uart_rx #(
        .DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(8),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx_b),
        .fifo_if (if_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int wr_c [2] = '{0, 0};
    int fe_c [2] = '{0, 0};
    int pe_c [2] = '{0, 0};
    int oe_c [2] = '{0, 0};
    int wr_b0 [2];
    int fe_b0 [2];
    int pe_b0 [2];
    int oe_b0 [2];

    always @(negedge clk) begin
        if (if_a.wr)          wr_c[0] <= wr_c[0] + 1;
        if (if_a.frame_err)   fe_c[0] <= fe_c[0] + 1;
        if (if_a.parity_err)  pe_c[0] <= pe_c[0] + 1;
        if (if_a.overrun_err) oe_c[0] <= oe_c[0] + 1;
        if (if_b.wr)          wr_c[1] <= wr_c[1] + 1;
        if (if_b.frame_err)   fe_c[1] <= fe_c[1] + 1;
        if (if_b.parity_err)  pe_c[1] <= pe_c[1] + 1;
        if (if_b.overrun_err) oe_c[1] <= oe_c[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic mark();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            wr_b0[i] = wr_c[i];
            fe_b0[i] = fe_c[i];
            pe_b0[i] = pe_c[i];
            oe_b0[i] = oe_c[i];
        end
    endtask

    task automatic chk_counts(input string tag, input int d,
                              input int ewr, input int efe, input int epe, input int eoe);
        @(negedge clk);
        chk({tag, ".wr"},      wr_c[d] - wr_b0[d], ewr);
        chk({tag, ".frame"},   fe_c[d] - fe_b0[d], efe);
        chk({tag, ".parity"},  pe_c[d] - pe_b0[d], epe);
        chk({tag, ".overrun"}, oe_c[d] - oe_b0[d], eoe);
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic hold_bit(input int d, input logic v, input int clks);
        set_rx(d, v);
        repeat (clks) @(posedge clk);
    endtask

    // Full frame followed by an idle gap long enough for the outcome pulse.
    // A low stop bit is released early so the receiver does not see a new start.
    task automatic send_frame(input int d, input logic [7:0] data, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        hold_bit(d, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++)
            hold_bit(d, data[i], BIT_CLK);
        if (with_par)
            hold_bit(d, par_bit, BIT_CLK);
        if (stop_bit)
            hold_bit(d, 1'b1, BIT_CLK);
        else
            hold_bit(d, 1'b0, 40);
        hold_bit(d, 1'b1, 2 * BIT_CLK);
    endtask

    initial begin
        reset        = 1'b1;
        rx_a         = 1'b1;
        rx_b         = 1'b1;
        if_a.fifo_full = 1'b0;
        if_b.fifo_full = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.wr",      if_a.wr, 0);
        chk("rst.frame",   if_a.frame_err, 0);
        chk("rst.parity",  if_a.parity_err, 0);
        chk("rst.overrun", if_a.overrun_err, 0);
        chk("rst.w_data",  if_a.w_data, 8'h00);
        @(posedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // 1: plain frame
        mark();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        chk_counts("s1", 0, 1, 0, 0, 0);
        chk("s1.w_data", if_a.w_data, 8'hA5);

        // 2: short glitch, then a good frame
        mark();
        hold_bit(0, 1'b0, 20);
        hold_bit(0, 1'b1, 2 * BIT_CLK);
        chk_counts("s2.glitch", 0, 0, 0, 0, 0);
        mark();
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        chk_counts("s2.frame", 0, 1, 0, 0, 0);
        chk("s2.w_data", if_a.w_data, 8'h3C);

        // 3: stop bit low
        hold_bit(0, 1'b1, BIT_CLK);
        mark();
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        chk_counts("s3", 0, 0, 1, 0, 0);
        chk("s3.w_data", if_a.w_data, 8'h3C);
        hold_bit(0, 1'b1, 2 * BIT_CLK);

        // 4: even parity, 0x07 has three ones so the parity bit must be 1
        mark();
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        chk_counts("s4.bad", 1, 0, 0, 1, 0);
        chk("s4.bad.w_data", if_b.w_data, 8'h07);
        mark();
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        chk_counts("s4.good", 1, 1, 0, 0, 0);
        chk("s4.good.w_data", if_b.w_data, 8'h07);

        // 5: overrun, then recovery
        if_a.fifo_full = 1'b1;
        mark();
        send_frame(0, 8'h55, 0, 1'b0, 1'b1);
        chk_counts("s5.full", 0, 0, 0, 0, 1);
        chk("s5.full.w_data", if_a.w_data, 8'h55);
        if_a.fifo_full = 1'b0;
        mark();
        send_frame(0, 8'hAA, 0, 1'b0, 1'b1);
        chk_counts("s5.ok", 0, 1, 0, 0, 0);
        chk("s5.ok.w_data", if_a.w_data, 8'hAA);

        // 6: reset in the middle of data bit 3 (frame 0xFF would give 1s)
        mark();
        hold_bit(0, 1'b0, BIT_CLK);
        hold_bit(0, 1'b1, BIT_CLK);
        hold_bit(0, 1'b0, BIT_CLK);
        hold_bit(0, 1'b1, BIT_CLK);
        hold_bit(0, 1'b0, BIT_CLK / 2);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s6.rst.wr",      if_a.wr, 0);
        chk("s6.rst.frame",   if_a.frame_err, 0);
        chk("s6.rst.parity",  if_a.parity_err, 0);
        chk("s6.rst.overrun", if_a.overrun_err, 0);
        chk("s6.rst.w_data",  if_a.w_data, 8'h00);
        @(posedge clk);
        rx_a  = 1'b1;
        reset = 1'b0;
        repeat (2 * BIT_CLK) @(posedge clk);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        chk_counts("s6", 0, 1, 0, 0, 0);
        chk("s6.w_data", if_a.w_data, 8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
